// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, packer state encoding, word geometry
// and the FIFO entry layout used by the receive packer.
package spi_pkg;

    localparam logic [7:0] READ_START  = 8'd1;
    localparam logic [7:0] READ_MORE   = 8'd2;
    localparam logic [7:0] WRITE_START = 8'd3;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;

    typedef enum logic {
        EMPTY   = 1'b0,
        PARTIAL = 1'b1
    } packState_t;

    typedef struct packed {
        logic [2:0]        nBytes;
        logic [WORD_W-1:0] data;
    } fifoEntry_t;

    // Low n bytes of 'shifted' are valid; move them to the top lanes.
    function automatic fifoEntry_t alignWord(
        input logic [WORD_W-1:0] shifted,
        input logic [2:0]        n
    );
        fifoEntry_t e;
        e.nBytes = n;
        e.data   = shifted << (8 * (LANES - int'(n)));
        return e;
    endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Word FIFO for the SPI receive packer: two write ports, one read port,
// first-word fall-through head, full/empty/free-slot status.
module spi_word_fifo
    import spi_pkg::*;
#(
    parameter int Depth = 16
) (
    input  logic                     SysClk,
    input  logic                     Reset,
    input  logic                     wrEn0,
    input  fifoEntry_t               wrData0,
    input  logic                     wrEn1,
    input  fifoEntry_t               wrData1,
    input  logic                     rdEn,
    output fifoEntry_t               rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   freeCount
);

    localparam int PW = $clog2(Depth);

    fifoEntry_t    mem [Depth];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] wrPtr1;
    logic [PW-1:0] rdPtr;
    logic [PW:0]   count;
    logic          doRead;

    assign doRead    = rdEn && !empty;
    assign wrPtr1    = wrPtr + PW'(wrEn0);
    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(Depth));
    assign freeCount = (PW+1)'(Depth) - count;
    assign rdData    = empty ? '0 : mem[rdPtr];

    always_ff @(posedge SysClk) begin
        if (wrEn0) begin
            mem[wrPtr] <= wrData0;
        end
        if (wrEn1) begin
            mem[wrPtr1] <= wrData1;
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(wrEn0) + PW'(wrEn1);
            rdPtr <= rdPtr + PW'(doRead);
            count <= count + (PW+1)'(wrEn0) + (PW+1)'(wrEn1)
                           - (PW+1)'(doRead);
        end
    end

endmodule

// File: rtl/spi_rx_packer.sv
// Packs the SPI receive byte stream big-endian into 32-bit words and queues
// them for a valid/ready consumer. Optional checksum: SPI_RX_PACK_CKSUM_EN.
module spi_rx_packer
    import spi_pkg::*;
#(
    parameter int AddrBits  = 12,
    parameter int FifoDepth = 16
) (
    input  logic                SysClk,
    input  logic                Reset,
    input  logic [AddrBits-1:0] rcMemAddr,
    input  logic [7:0]          rcMemData,
    input  logic                rcMemWE,
    input  logic                flush,
    output logic [WORD_W-1:0]   wordData,
    output logic [2:0]          wordBytes,
    output logic                wordValid,
    input  logic                wordReady,
    output logic [AddrBits:0]   byteCount,
    output logic                overflow
`ifdef SPI_RX_PACK_CKSUM_EN
    ,
    output logic [7:0]          cksum
`endif
);

    localparam int PW = $clog2(FifoDepth);

    packState_t  state;
    packState_t  nextState;
    logic [1:0]  lane;
    logic [1:0]  nextLane;
    logic [23:0] acc;
    logic [23:0] nextAcc;

    logic        isStart;
    logic        push0;
    logic        push1;
    fifoEntry_t  word0;
    fifoEntry_t  word1;
    fifoEntry_t  head;

    logic        pop;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [PW:0] freeCount;
    logic [PW+1:0] effFree;
    logic        wrEn0;
    logic        wrEn1;
    logic        dropWord;

    assign isStart = rcMemWE && (rcMemAddr == '0);

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state <= EMPTY;
            lane  <= '0;
            acc   <= '0;
        end else begin
            state <= nextState;
            lane  <= nextLane;
            acc   <= nextAcc;
        end
    end

    always_comb begin
        nextState = state;
        nextLane  = lane;
        nextAcc   = acc;
        push0     = 1'b0;
        push1     = 1'b0;
        word0     = '0;
        word1     = '0;
        if (isStart) begin
            if (state == PARTIAL) begin
                push0 = 1'b1;
                word0 = alignWord({8'h00, acc}, {1'b0, lane});
            end
            if (flush) begin
                // New byte goes out alone, behind any held partial word.
                if (state == PARTIAL) begin
                    push1 = 1'b1;
                    word1 = alignWord({24'h0, rcMemData}, 3'd1);
                end else begin
                    push0 = 1'b1;
                    word0 = alignWord({24'h0, rcMemData}, 3'd1);
                end
                nextState = EMPTY;
                nextLane  = '0;
                nextAcc   = '0;
            end else begin
                nextState = PARTIAL;
                nextLane  = 2'd1;
                nextAcc   = {16'h0, rcMemData};
            end
        end else if (rcMemWE) begin
            if (lane == 2'd3 || flush) begin
                push0     = 1'b1;
                word0     = alignWord({acc, rcMemData},
                                      {1'b0, lane} + 3'd1);
                nextState = EMPTY;
                nextLane  = '0;
                nextAcc   = '0;
            end else begin
                nextState = PARTIAL;
                nextLane  = lane + 2'd1;
                nextAcc   = {acc[15:0], rcMemData};
            end
        end else if (flush && state == PARTIAL) begin
            push0     = 1'b1;
            word0     = alignWord({8'h00, acc}, {1'b0, lane});
            nextState = EMPTY;
            nextLane  = '0;
            nextAcc   = '0;
        end
    end

    // A pop in the same cycle frees its slot for this cycle's writes.
    assign pop      = wordValid && wordReady;
    assign effFree  = {1'b0, freeCount} + (PW+2)'(pop);
    assign wrEn0    = push0 && (!fifoFull || pop);
    assign wrEn1    = push1 && (effFree >= (PW+2)'(2));
    assign dropWord = (push0 && !wrEn0) || (push1 && !wrEn1);

    spi_word_fifo #(
        .Depth     (FifoDepth)
    ) uFifo (
        .SysClk    (SysClk),
        .Reset     (Reset),
        .wrEn0     (wrEn0),
        .wrData0   (word0),
        .wrEn1     (wrEn1),
        .wrData1   (word1),
        .rdEn      (pop),
        .rdData    (head),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .freeCount (freeCount)
    );

    assign wordValid = !fifoEmpty;
    assign wordData  = head.data;
    assign wordBytes = head.nBytes;

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            byteCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (isStart) begin
                byteCount <= (AddrBits+1)'(1);
            end else if (rcMemWE && byteCount != '1) begin
                byteCount <= byteCount + 1'b1;
            end
            if (dropWord) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef SPI_RX_PACK_CKSUM_EN
    always_ff @(posedge SysClk) begin
        if (Reset) begin
            cksum <= '0;
        end else if (isStart) begin
            cksum <= rcMemData;
        end else if (rcMemWE) begin
            cksum <= cksum + rcMemData;
        end
    end
`endif

endmodule

// File: tb/tb_spi_rx_packer.sv
// Self-checking bench for spi_rx_packer: vector table plus scoreboard of
// expected words, with hand sequences for overflow, reset and checksum.
module tb_spi_rx_packer;

    logic        SysClk;
    logic        Reset;
    logic [11:0] rcMemAddr;
    logic [7:0]  rcMemData;
    logic        rcMemWE;
    logic        flush;
    logic [31:0] wordData;
    logic [2:0]  wordBytes;
    logic        wordValid;
    logic        wordReady;
    logic [12:0] byteCount;
    logic        overflow;
`ifdef SPI_RX_PACK_CKSUM_EN
    logic [7:0]  cksum;
`endif

    spi_rx_packer #(
        .AddrBits  (12),
        .FifoDepth (16)
    ) dut (
        .SysClk    (SysClk),
        .Reset     (Reset),
        .rcMemAddr (rcMemAddr),
        .rcMemData (rcMemData),
        .rcMemWE   (rcMemWE),
        .flush     (flush),
        .wordData  (wordData),
        .wordBytes (wordBytes),
        .wordValid (wordValid),
        .wordReady (wordReady),
        .byteCount (byteCount),
        .overflow  (overflow)
`ifdef SPI_RX_PACK_CKSUM_EN
        ,
        .cksum     (cksum)
`endif
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    int nChecks = 0;
    int nFails  = 0;
    logic [34:0] sb [$];

    typedef struct {
        logic        we;
        int          addr;
        int          data;
        logic        fl;
        int          nPush;
        logic [34:0] e0;
        logic [34:0] e1;
        int          bc;
        logic        vld;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [34:0] ent(input int n, input logic [31:0] d);
        logic [2:0] b;
        b = n[2:0];
        return {b, d};
    endfunction

    function automatic vec_t mkv(input logic we, input int addr,
                                 input int data, input logic fl,
                                 input int nPush, input logic [34:0] e0,
                                 input logic [34:0] e1, input int bc,
                                 input logic vld);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.fl = fl;
        v.nPush = nPush; v.e0 = e0; v.e1 = e1; v.bc = bc; v.vld = vld;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic we, input int addr, input int data,
                        input logic fl);
        rcMemWE   = we;
        rcMemAddr = addr[11:0];
        rcMemData = data[7:0];
        flush     = fl;
        @(posedge SysClk);
        #1;
        rcMemWE = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        @(posedge SysClk);
        #1;
        Reset = 1'b0;
        sb.delete();
    endtask

    // Consumer side: every accepted word must match the scoreboard head.
    always @(negedge SysClk) begin
        if (!Reset && wordValid && wordReady) begin
            if (sb.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL pop_unexpected: got %h/%0d expected none",
                         wordData, wordBytes);
            end else begin
                logic [34:0] e;
                e = sb.pop_front();
                chk("pop_data", {32'h0, wordData}, {32'h0, e[31:0]});
                chk("pop_bytes", {61'h0, wordBytes}, {61'h0, e[34:32]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        Reset = 1'b1; rcMemWE = 1'b0; rcMemAddr = '0;
        rcMemData = '0; flush = 1'b0; wordReady = 1'b1;
        @(posedge SysClk); #1;
        doReset();
        chk("rst_valid", {63'h0, wordValid}, 64'h0);
        chk("rst_data", {32'h0, wordData}, 64'h0);
        chk("rst_bytes", {61'h0, wordBytes}, 64'h0);
        chk("rst_ovf", {63'h0, overflow}, 64'h0);
        chk("rst_bc", {51'h0, byteCount}, 64'h0);
`ifdef SPI_RX_PACK_CKSUM_EN
        chk("rst_cksum", {56'h0, cksum}, 64'h0);
`endif

        tbl[0]  = mkv(1, 0, 'h11, 0, 0, '0, '0, 1, 0);
        tbl[1]  = mkv(1, 1, 'h22, 0, 0, '0, '0, 2, 0);
        tbl[2]  = mkv(1, 2, 'h33, 0, 0, '0, '0, 3, 0);
        tbl[3]  = mkv(1, 3, 'h44, 0, 1, ent(4, 32'h11223344), '0, 4, 1);
        tbl[4]  = mkv(1, 0, 'hAA, 0, 0, '0, '0, 1, 0);
        tbl[5]  = mkv(1, 1, 'hBB, 0, 0, '0, '0, 2, 0);
        tbl[6]  = mkv(0, 0, 0, 1, 1, ent(2, 32'hAABB0000), '0, 2, 1);
        tbl[7]  = mkv(0, 0, 0, 1, 0, '0, '0, 2, 0);
        tbl[8]  = mkv(1, 0, 'h01, 0, 0, '0, '0, 1, 0);
        tbl[9]  = mkv(1, 1, 'h02, 0, 0, '0, '0, 2, 0);
        tbl[10] = mkv(1, 2, 'h03, 0, 0, '0, '0, 3, 0);
        tbl[11] = mkv(1, 0, 'h55, 0, 1, ent(3, 32'h01020300), '0, 1, 1);
        tbl[12] = mkv(0, 0, 0, 1, 1, ent(1, 32'h55000000), '0, 1, 1);
        tbl[13] = mkv(1, 0, 'h66, 0, 0, '0, '0, 1, 0);
        tbl[14] = mkv(1, 1, 'h77, 1, 1, ent(2, 32'h66770000), '0, 2, 1);
        tbl[15] = mkv(1, 0, 'h88, 0, 0, '0, '0, 1, 0);
        tbl[16] = mkv(1, 1, 'h99, 0, 0, '0, '0, 2, 0);
        tbl[17] = mkv(1, 0, 'h5A, 1, 2, ent(2, 32'h88990000),
                      ent(1, 32'h5A000000), 1, 1);
        tbl[18] = mkv(0, 0, 0, 0, 0, '0, '0, 1, 1);
        tbl[19] = mkv(1, 0, 'hC1, 0, 0, '0, '0, 1, 0);
        tbl[20] = mkv(1, 7, 'hC2, 0, 0, '0, '0, 2, 0);
        tbl[21] = mkv(1, 3, 'hC3, 0, 0, '0, '0, 3, 0);
        tbl[22] = mkv(1, 9, 'hC4, 0, 1, ent(4, 32'hC1C2C3C4), '0, 4, 1);
        tbl[23] = mkv(0, 0, 0, 0, 0, '0, '0, 4, 0);

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].nPush >= 1) sb.push_back(tbl[i].e0);
            if (tbl[i].nPush >= 2) sb.push_back(tbl[i].e1);
            step(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].fl);
            chk($sformatf("vec%0d_bc", i), {51'h0, byteCount},
                64'(tbl[i].bc));
            chk($sformatf("vec%0d_valid", i), {63'h0, wordValid},
                {63'h0, tbl[i].vld});
        end

        // Stalled consumer: 16 words fit, the 17th is dropped.
        wordReady = 1'b0;
        for (int k = 0; k < 17; k++) begin
            w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            if (k < 16) sb.push_back({3'd4, w});
            for (int b = 0; b < 4; b++) step(1, 4*k+b, 4*k+b, 0);
            if (k == 15) chk("full_no_ovf", {63'h0, overflow}, 64'h0);
        end
        chk("ovf_set", {63'h0, overflow}, 64'h1);
        chk("ovf_valid", {63'h0, wordValid}, 64'h1);
        chk("ovf_head_stable", {32'h0, wordData}, 64'h00010203);
        chk("ovf_bc", {51'h0, byteCount}, 64'd68);
        wordReady = 1'b1;
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0);
        chk("drain_valid", {63'h0, wordValid}, 64'h0);
        chk("drain_ovf_sticky", {63'h0, overflow}, 64'h1);
        chk("drain_sb", 64'(sb.size()), 64'h0);

        // Flush+start double push with a single free slot.
        doReset();
        chk("rst2_ovf", {63'h0, overflow}, 64'h0);
        wordReady = 1'b0;
        for (int k = 0; k < 15; k++) begin
            w = {8'(128+4*k), 8'(129+4*k), 8'(130+4*k), 8'(131+4*k)};
            sb.push_back({3'd4, w});
            for (int b = 0; b < 4; b++) step(1, 4*k+b, 128+4*k+b, 0);
        end
        step(1, 0, 'hE1, 0);
        step(1, 1, 'hE2, 0);
        chk("one_slot_no_ovf", {63'h0, overflow}, 64'h0);
        sb.push_back(ent(2, 32'hE1E20000));
        step(1, 0, 'hE3, 1);
        chk("one_slot_ovf", {63'h0, overflow}, 64'h1);
        chk("one_slot_bc", {51'h0, byteCount}, 64'd1);
        wordReady = 1'b1;
        for (int i = 0; i < 17; i++) step(0, 0, 0, 0);
        chk("drain2_sb", 64'(sb.size()), 64'h0);

        // Reset mid-word discards the held lanes.
        step(1, 0, 'hD1, 0);
        step(1, 1, 'hD2, 0);
        doReset();
        chk("mid_rst_valid", {63'h0, wordValid}, 64'h0);
        chk("mid_rst_data", {32'h0, wordData}, 64'h0);
        chk("mid_rst_bc", {51'h0, byteCount}, 64'h0);
        step(1, 5, 'hA1, 0);
        step(1, 6, 'hA2, 0);
        step(1, 7, 'hA3, 0);
        sb.push_back(ent(3, 32'hA1A2A300));
        step(0, 0, 0, 1);
        sb.push_back(ent(4, 32'hB1B2B3B4));
        for (int b = 0; b < 4; b++) step(1, 8+b, 'hB1+b, 0);
        chk("post_rst_bc", {51'h0, byteCount}, 64'd7);

`ifdef SPI_RX_PACK_CKSUM_EN
        step(1, 0, 'hF0, 0);
        step(1, 1, 'h20, 0);
        step(1, 2, 'h05, 0);
        chk("cksum_sum", {56'h0, cksum}, 64'h15);
        sb.push_back(ent(3, 32'hF0200500));
        step(1, 0, 'h07, 0);
        chk("cksum_reload", {56'h0, cksum}, 64'h07);
        sb.push_back(ent(1, 32'h07000000));
        step(0, 0, 0, 1);
`endif

        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("final_sb", 64'(sb.size()), 64'h0);
        chk("final_valid", {63'h0, wordValid}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/spi_rx_packer.md
# spi_rx_packer

Downstream consumer of the SPI interface's receive-memory write port. Takes the byte-wide write stream (address, data, write-enable), packs bytes big-endian into 32-bit words, and queues them in a small FIFO. A SysClk-domain client drains the FIFO through a valid/ready handshake, so the receive buffer becomes a word stream for a processor bus or DMA.

## Interface
- AddrBits, 12: width of the incoming byte address.
- FifoDepth, 16: word FIFO entries; power of two, ≥2.
- SysClk  in  1  sole clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- rcMemAddr  in  AddrBits  byte address of the incoming write; 0 marks the start of a transfer.
- rcMemData  in  8  incoming byte.
- rcMemWE  in  1  byte-valid strobe, one byte per high cycle, SysClk-synchronous.
- flush  in  1  pulse; emit any partial word.
- wordData  out  32  head word; first byte in [31:24], unused low lanes zero.
- wordBytes  out  3  valid bytes in the head word, 1–4.
- wordValid  out  1  FIFO not empty.
- wordReady  in  1  consumer accepts the head word when wordValid && wordReady.
- byteCount  out  AddrBits+1  bytes accepted since the last transfer start; saturates at all-ones.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- cksum  out  8  (only with SPI_RX_PACK_CKSUM_EN) running checksum.

## Operation
- Accumulator: a 24-bit shift holding register plus a lane counter, 0–3.
- States:
  - EMPTY (lane=0) and PARTIAL (lane 1–3).
  - A byte in EMPTY → PARTIAL with lane=1.
  - The 4th byte forms a full word, pushes it with wordBytes=4, and returns to EMPTY.
- Transfer start (rcMemWE && rcMemAddr==0):
  - In PARTIAL, the held partial word is pushed first, with wordBytes=lane.
  - In the same cycle the new byte becomes lane 0 of a fresh accumulator.
  - byteCount restarts at 1.
- Address gaps other than 0 are ignored; bytes pack in arrival order.
- flush:
  - In PARTIAL, push the partial word and go to EMPTY.
  - In EMPTY, no-op.
  - Flush with a simultaneous byte: the byte is appended first, then the resulting word (1–4 bytes) is pushed.
  - Flush with a simultaneous addr-0 byte: the old partial is pushed, and the new byte is pushed alone as a 1-byte word.
- Push into a full FIFO (a pop in the same cycle counts as not full): the word is dropped, overflow is set, and the accumulator still advances.
- At most one push per cycle, except the flush+addr-0 case, which needs two pushes. There:
  - If only one slot is free, the second word is dropped and overflow is set.
  - The FIFO accepts two writes per cycle.
- Reset:
  - Empties the FIFO and the accumulator, and clears overflow, byteCount and cksum.
  - Reset mid-word discards the partial data without emitting it.

## Timing
- Reset values:
  - wordValid=0, wordData=0, wordBytes=0.
  - overflow=0, byteCount=0, cksum=0.
- Push latency: a word completed by the byte in cycle N is written at the end of N and appears as wordValid=1 in N+1 (first-word fall-through, registered).
- Pop: on a cycle where wordValid && wordReady, the next entry (if any) is presented in the following cycle. Sustained throughput is 1 word per cycle.
- Handshake rules:
  - wordData and wordBytes stay stable while wordValid && !wordReady.
  - wordValid never drops without a pop.
- byteCount and cksum update at the end of the cycle in which the byte is accepted.

## Configuration
- SPI_RX_PACK_CKSUM_EN defined:
  - cksum port and logic present.
  - 8-bit additive checksum (mod 256) of all bytes accepted since the last transfer start.
  - The addr-0 byte reloads cksum with that byte.
- Undefined: cksum port and logic absent; all other behaviour identical.

## Structure
- Shared package spi_pkg holds:
  - SPI command constants: READ_START=1, READ_MORE=2, WRITE_START=3.
  - Packer state encoding (EMPTY/PARTIAL).
  - WORD_W=32 and the byte-lane count.
- Sub-module spi_word_fifo:
  - Synchronous FIFO of 35-bit entries: data plus wordBytes.
  - Two write ports, one read port, first-word fall-through.
  - Depth FifoDepth.
  - Outputs full, empty and free-slot count.

## Test plan
- Bytes 11,22,33,44 at addr 0..3, wordReady=1 → one word 0x11223344, wordBytes=4, wordValid high one cycle after the 4th byte; byteCount=4.
- Bytes AA,BB at addr 0,1 then flush → word 0xAABB0000, wordBytes=2; a flush on an empty accumulator produces no word.
- Bytes 01,02,03 then addr-0 byte 55 → word 0x01020300 (3 bytes) pushed; the accumulator holds 55 in lane 0; byteCount=1.
- wordReady=0, 17 full words (68 bytes) → 16 words held, overflow=1; drain → words in order, overflow still 1 until Reset.
- Reset asserted after 2 bytes → outputs zero; the next 4 bytes form a clean word with no stale lanes.
- With SPI_RX_PACK_CKSUM_EN: bytes F0,20,05 → cksum=0x15; an addr-0 byte 07 → cksum=0x07.
